// File: rtl/cms_pkg.sv
// Shared definitions for the trace capture controller: FSM state type and the
// state encodings reported to software on the state status output.
package cms_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMED     = 2'd1,
        CAPTURING = 2'd2,
        DRAINING  = 2'd3
    } cms_state_e;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_ARMED     = 2'd1;
    localparam logic [1:0] ST_CAPTURING = 2'd2;
    localparam logic [1:0] ST_DRAINING  = 2'd3;

endpackage

// File: rtl/trace_trigger_match.sv
// Start/stop PC comparators, qualified by pc_valid, for the trace capture controller.
module trace_trigger_match
    import cms_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_pc_valid,
    input  logic [XLEN-1:0] i_start_addr,
    input  logic [XLEN-1:0] i_stop_addr,
    output logic            o_start_hit,
    output logic            o_stop_hit
);

    // Full-width equality against both trigger addresses
    always_comb begin
        o_start_hit = i_pc_valid & (i_pc == i_start_addr);
        o_stop_hit  = i_pc_valid & (i_pc == i_stop_addr);
    end

endmodule

// File: rtl/trace_capture_controller.sv
// Sequences committed-instruction trace capture into the AXI-Stream packer:
// arm, start at a PC, stop at a PC or item limit, then wait for the packer to drain.
module trace_capture_controller
    import cms_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [XLEN-1:0]  pc,
    input  logic             pc_valid,
    input  logic             drop_instr,
    input  logic             fifo_full,
    input  logic             fifo_empty,
    input  logic [XLEN-1:0]  cfg_start_addr,
    input  logic [XLEN-1:0]  cfg_stop_addr,
    input  logic [CNT_W-1:0] cfg_max_items,
    input  logic             cfg_arm,
    input  logic             cfg_abort,
    output logic             write_enable,
    output logic             last_item,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] capture_count,
    output logic             done,
    output logic             overflow
);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_count;
    logic             r_done;
    logic             r_overflow;

    logic w_start_hit;
    logic w_stop_hit;
    logic w_qualify;
    logic w_limit;
    logic w_cand;
    logic w_we;
    logic w_lost;
    logic w_term;
    logic w_last;

    trace_trigger_match #(
        .XLEN (XLEN)
    ) u_trigger (
        .i_pc         (pc),
        .i_pc_valid   (pc_valid),
        .i_start_addr (cfg_start_addr),
        .i_stop_addr  (cfg_stop_addr),
        .o_start_hit  (w_start_hit),
        .o_stop_hit   (w_stop_hit)
    );

    // Per-cycle item decode: a candidate item is either written or lost to fifo_full
    always_comb begin
        w_qualify = pc_valid & (~drop_instr | w_start_hit | w_stop_hit);
        w_limit   = (cfg_max_items != {CNT_W{1'b0}}) &&
                    ((r_count + CNT_W'(1)) == cfg_max_items);
        case (r_state)
            ST_ARMED:     w_cand = w_start_hit & ~cfg_abort;
            ST_CAPTURING: w_cand = w_qualify & ~cfg_abort;
            default:      w_cand = 1'b0;
        endcase
        w_we   = w_cand & ~fifo_full;
        w_lost = w_cand & fifo_full;
        w_term = w_cand & (w_stop_hit | w_limit);
        w_last = w_we & w_term;
    end

    // Capture FSM; abort outranks triggers, a lost terminal item still ends capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cfg_arm) r_state <= ST_ARMED;
                    else         r_state <= ST_IDLE;
                end
                ST_ARMED: begin
                    if (cfg_abort)        r_state <= ST_IDLE;
                    else if (w_term)      r_state <= ST_DRAINING;
                    else if (w_start_hit) r_state <= ST_CAPTURING;
                    else                  r_state <= ST_ARMED;
                end
                ST_CAPTURING: begin
                    if (cfg_abort || w_term) r_state <= ST_DRAINING;
                    else                     r_state <= ST_CAPTURING;
                end
                ST_DRAINING: begin
                    if (fifo_empty) r_state <= ST_IDLE;
                    else            r_state <= ST_DRAINING;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Item counter and sticky status; arming starts a fresh capture record
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count    <= {CNT_W{1'b0}};
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
        end else if ((r_state == ST_IDLE) && cfg_arm) begin
            r_count    <= {CNT_W{1'b0}};
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_we) r_count <= r_count + CNT_W'(1);
            else      r_count <= r_count;
            if ((r_state == ST_DRAINING) && fifo_empty) r_done <= 1'b1;
            else                                         r_done <= r_done;
            if (w_lost) r_overflow <= 1'b1;
            else        r_overflow <= r_overflow;
        end
    end

    assign write_enable  = w_we;
    assign last_item     = w_last;
    assign state         = r_state;
    assign capture_count = r_count;
    assign done          = r_done;
    assign overflow      = r_overflow;

endmodule

// File: doc/trace_capture_controller.md
# trace_capture_controller

Sequences capture of the committed-instruction trace into the trace AXI-Stream packer. It sits between the trace filter and the stream packer, and drives the packer's write enable. It arms on software command, starts capture at a programmed PC, and stops at a programmed PC or an item-count limit. The last captured item is flagged so the packer closes the packet with tlast, and the packer must drain before the controller returns to idle.

## Interface
- XLEN, 64: PC width.
- CNT_W, 32: width of the item-limit input and the capture counter.

- clk  in  1  clock.
- rst_n  in  1  reset: synchronous, active-low.
- pc  in  XLEN  committed PC.
- pc_valid  in  1  pc/instr valid this cycle.
- drop_instr  in  1  trace filter requests the instruction be dropped.
- fifo_full  in  1  packer cannot accept a write this cycle.
- fifo_empty  in  1  packer has fully drained (all items sent on AXI).
- cfg_start_addr  in  XLEN  start-trigger PC.
- cfg_stop_addr  in  XLEN  stop-trigger PC.
- cfg_max_items  in  CNT_W  item limit; 0 means unlimited.
- cfg_arm  in  1  single-cycle arm command.
- cfg_abort  in  1  single-cycle abort command.
- write_enable  out  1  write {pc, instr} into the packer this cycle.
- last_item  out  1  the item being written is the final item; the packer forces tlast on it.
- state  out  2  IDLE=0, ARMED=1, CAPTURING=2, DRAINING=3.
- capture_count  out  CNT_W  items written in the current capture.
- done  out  1  sticky; set when a capture completes.
- overflow  out  1  sticky; set when a qualifying item is lost to fifo_full.

## Operation
- Definitions:
  - start_hit = pc_valid & (pc == cfg_start_addr).
  - stop_hit = pc_valid & (pc == cfg_stop_addr).
  - qualify = pc_valid & (~drop_instr | start_hit | stop_hit). Trigger instructions are never dropped.
- IDLE:
  - write_enable = 0.
  - cfg_arm causes the following, and moves to ARMED: clear capture_count, done and overflow.
- ARMED:
  - On start_hit, the start instruction is written (start-inclusive), then move to CAPTURING.
  - If stop_hit or the limit is also met on that same item, last_item = 1 and the state goes directly to DRAINING.
- CAPTURING:
  - write_enable = qualify & ~fifo_full & ~cfg_abort.
  - Terminal item = stop_hit, or (cfg_max_items != 0 and capture_count + 1 == cfg_max_items).
  - On the terminal item: last_item = 1 together with write_enable, then move to DRAINING.
- DRAINING:
  - write_enable = 0.
  - Leave when fifo_empty is sampled 1: set done and move to IDLE.
- Counter and overflow rules:
  - capture_count increments on every asserted write_enable.
  - capture_count wraps modulo 2^CNT_W when unlimited.
  - A qualifying item with fifo_full = 1 is lost: overflow is set and the count is not incremented.
  - A lost terminal item still moves to DRAINING, with no last_item.
- cfg_abort:
  - From ARMED, go to IDLE.
  - From CAPTURING, go to DRAINING with no last_item.
  - Ignored in IDLE and DRAINING.
  - Abort has priority over the arm command and over triggers in the same cycle.
- cfg_arm outside IDLE is ignored.
- cfg_* inputs must be stable while not IDLE; a change in that window has undefined effect.

## Timing
- write_enable and last_item are combinational from pc_valid, pc, drop_instr, fifo_full, cfg_abort and the registered state. This gives zero latency, aligned with the pc/instr the packer samples.
- state, capture_count, done and overflow are registered and update on the edge after the causing cycle.
- Minimum cycles:
  - arm to first possible write: 1 cycle.
  - Terminal write to DRAINING: 1 cycle.
  - DRAINING to IDLE: 1 cycle after fifo_empty is seen.
- Reset (rst_n low at an edge) has effect in any state, mid-capture included. Reset values:
  - state = IDLE; capture_count, done and overflow = 0.
  - write_enable and last_item = 0.
- Items already in the packer are not the controller's concern after reset.

## Structure
- Shared package cms_pkg holds:
  - the 2-bit state enum (IDLE, ARMED, CAPTURING, DRAINING);
  - the state encoding constants used by software status reads.
- One natural sub-module, trace_trigger_match: the two XLEN-wide PC comparators gated by pc_valid, producing start_hit and stop_hit. The FSM, counter and sticky flags stay in the top.

## Test plan
- Arm, cfg_start_addr=0x1000, cfg_stop_addr=0x1010, cfg_max_items=0, stepped PCs 0xFF8..0x1018 -> writes for 0x1000..0x1010 (5 items) with last_item on 0x1010; capture_count=5; DRAINING until fifo_empty; then done=1, state=IDLE.
- cfg_max_items=3, stop never hit -> exactly 3 writes, last_item on the 3rd, capture_count=3.
- cfg_start_addr = cfg_stop_addr = 0x2000 -> single write with last_item, state ARMED→DRAINING directly.
- drop_instr=1 on all instructions including the start and stop PCs -> only the start and stop items are written, capture_count=2.
- fifo_full=1 for 2 cycles mid-capture -> those 2 items are not written, overflow=1, count excludes them; cfg_abort in the same cycle as a stop_hit -> no write, no last_item, DRAINING.
- rst_n low for one cycle while CAPTURING with capture_count=7 -> next cycle state=IDLE, capture_count=0, done=0, write_enable=0.
